// File: rtl/mod503_pkg.sv
//------------------------------------------------------------------------------
// mod503_pkg
// Shared constants and types for the sequential mod-503 request scheduler:
// the modulus, the Horner digit width (one digit reduced per cycle), the
// operand width, the digit count per operand (a 2-bit top digit plus 22 full
// 9-bit digits), the fold weight 2^CHUNK_W mod 503, and the operand register
// width, zero-padded to a whole number of digits.
//------------------------------------------------------------------------------
package mod503_pkg;

   localparam int MOD      = 503;
   localparam int CHUNK_W  = 9;
   localparam int X_W      = 200;
   localparam int N_CHUNKS = 23;
   localparam int FOLD_K   = 9;
   localparam int OP_W     = N_CHUNKS * CHUNK_W;
   localparam int CNT_W    = $clog2(N_CHUNKS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/mod503_horner_step.sv
//------------------------------------------------------------------------------
// mod503_horner_step
// One Horner step of the mod-503 reduction: acc_next = (acc*512 + chunk) mod 503,
// using 512 == 9 (mod 503). Purely combinational.
// Ports:
//   acc_i       [8:0]  running remainder, 0..502
//   chunk_i     [8:0]  next 9-bit digit of the operand, MSB-first
//   acc_next_o  [8:0]  updated remainder, 0..502
//------------------------------------------------------------------------------
module mod503_horner_step
   import mod503_pkg::*;
(
   input  logic [CHUNK_W-1:0] acc_i,
   input  logic [CHUNK_W-1:0] chunk_i,
   output logic [CHUNK_W-1:0] acc_next_o
);

   logic [12:0] t1;
   logic [9:0]  t2;

   always_comb begin
      // acc*512 folds to acc*9; the sum stays below 2^13
      t1 = 13'(acc_i) * 13'(FOLD_K) + 13'(chunk_i);
      // fold the bits above the 9-bit digit a second time; result < 2*MOD,
      // so a single conditional subtract finishes the reduction
      t2 = 10'(t1[8:0]) + 10'(t1[12:9]) * 10'(FOLD_K);
      if (t2 >= 10'(MOD))
         acc_next_o = 9'(t2 - 10'(MOD));
      else
         acc_next_o = t2[8:0];
   end

endmodule

// File: rtl/mod503_req_sched.sv
//------------------------------------------------------------------------------
// mod503_req_sched
// Shares one sequential mod-503 reducer between NREQ requesters. An arbiter
// grants one valid requester while idle; the 200-bit operand is then reduced
// one 9-bit digit per cycle (23 cycles) and the remainder is held on the
// result port until the consumer takes it.
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   req_valid    [NREQ]       operand offered by requester i
//   req_x        [NREQ*X_W]   operand i in bits [i*X_W +: X_W]
//   req_ready    [NREQ]       one-hot grant, only while idle
//   res_valid    result available
//   res_ready    consumer accepts result
//   res_r        [9]          operand mod 503
//   res_id       [ID_W]       index of the requester owning res_r
// Build option:
//   MOD503_SCHED_FIXED_PRIO_EN  defined: fixed priority, lowest index wins,
//                               no round-robin pointer. Default: round-robin.
//------------------------------------------------------------------------------
module mod503_req_sched
   import mod503_pkg::*;
#(
   parameter  int NREQ = 4,
   parameter  int X_W  = 200,
   localparam int ID_W = $clog2(NREQ)
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*X_W-1:0]  req_x,
   output logic [NREQ-1:0]      req_ready,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [CHUNK_W-1:0]   res_r,
   output logic [ID_W-1:0]      res_id
);

   state_e               state_q;
   logic [OP_W-1:0]      op_q;
   logic [CHUNK_W-1:0]   acc_q;
   logic [CHUNK_W-1:0]   acc_d;
   logic [CNT_W-1:0]     cnt_q;
   logic [ID_W-1:0]      id_q;
   logic                 res_valid_q;

   logic [NREQ-1:0]      gnt_oh;
   logic [ID_W-1:0]      gnt_idx;
   logic                 gnt_any;
   logic [X_W-1:0]       op_sel;

`ifndef MOD503_SCHED_FIXED_PRIO_EN
   logic [ID_W-1:0]      rr_ptr_q;
   logic [ID_W-1:0]      rr_ptr_d;
`endif

   //---------------------------------------------------------------------------
   // Arbiter: only searches while idle, so nothing in DONE (incl. res_ready)
   // can reach req_ready combinationally.
   //---------------------------------------------------------------------------
   always_comb begin
      logic [ID_W-1:0] idx;
      int              sum;
      gnt_oh  = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      idx     = '0;
      sum     = 0;
      if (state_q == IDLE) begin
         for (int k = 0; k < NREQ; k++) begin
`ifdef MOD503_SCHED_FIXED_PRIO_EN
            sum = k;
`else
            sum = int'(rr_ptr_q) + k;
            if (sum >= NREQ) sum = sum - NREQ;
`endif
            idx = ID_W'(sum);
            if (!gnt_any && req_valid[idx]) begin
               gnt_any     = 1'b1;
               gnt_idx     = idx;
               gnt_oh[idx] = 1'b1;
            end
         end
      end
   end

`ifndef MOD503_SCHED_FIXED_PRIO_EN
   assign rr_ptr_d = (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
`endif

   assign req_ready = gnt_oh;

   // one-hot AND-OR operand select
   always_comb begin
      op_sel = '0;
      for (int i = 0; i < NREQ; i++)
         if (gnt_oh[i]) op_sel = op_sel | req_x[i*X_W +: X_W];
   end

   // top digit of the (zero-padded) operand register feeds the step unit
   mod503_horner_step u_step (
      .acc_i      (acc_q),
      .chunk_i    (op_q[OP_W-1 -: CHUNK_W]),
      .acc_next_o (acc_d)
   );

   //---------------------------------------------------------------------------
   // Control FSM with registered outputs
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         op_q        <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         id_q        <= '0;
         res_valid_q <= 1'b0;
`ifndef MOD503_SCHED_FIXED_PRIO_EN
         rr_ptr_q    <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (gnt_any) begin
                  state_q  <= RUN;
                  // padding puts the 2-bit top digit in a full 9-bit slot
                  op_q     <= OP_W'(op_sel);
                  acc_q    <= '0;
                  id_q     <= gnt_idx;
                  cnt_q    <= CNT_W'(N_CHUNKS - 1);
`ifndef MOD503_SCHED_FIXED_PRIO_EN
                  rr_ptr_q <= rr_ptr_d;
`endif
               end
            end
            RUN: begin
               acc_q <= acc_d;
               op_q  <= op_q << CHUNK_W;
               if (cnt_q == '0) begin
                  state_q     <= DONE;
                  res_valid_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            DONE: begin
               if (res_ready) begin
                  state_q     <= IDLE;
                  res_valid_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // acc and id are untouched in DONE, so the result holds through a stall
   assign res_valid = res_valid_q;
   assign res_r     = acc_q;
   assign res_id    = id_q;

endmodule

// File: tb/tb_mod503_req_sched.sv
module tb_mod503_req_sched;

   localparam int NREQ = 4;
   localparam int X_W  = 200;
   localparam int ID_W = 2;
   localparam int LAT  = 24;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ*X_W-1:0] req_x;
   logic [NREQ-1:0]     req_ready;
   logic                res_valid;
   logic                res_ready = 1'b1;
   logic [8:0]          res_r;
   logic [ID_W-1:0]     res_id;

   // driver-side requester state
   logic [NREQ-1:0]     v = '0;
   logic [X_W-1:0]      xs [NREQ];
   logic [X_W-1:0]      xq [NREQ][$];

   typedef struct { int id; int r; } exp_t;
   exp_t expq[$];

   int n_chk = 0, n_fail = 0;
   int cyc = 0;
   int busy = 0, acc_cyc = 0, rr_m = 0;
   int rdy_mode = 0;
   int tput_on = 0, last_hs = -1;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign req_valid = v;
   for (genvar g = 0; g < NREQ; g++) begin : g_x
      assign req_x[g*X_W +: X_W] = xs[g];
   end

   mod503_req_sched #(.NREQ(NREQ), .X_W(X_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_x     (req_x),
      .req_ready (req_ready),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_r     (res_r),
      .res_id    (res_id)
   );

   task automatic chk(input string nm, input longint got, input longint exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   // reference: bit-serial remainder, r = (2r + bit) mod 503
   function automatic int mod_ref(input logic [X_W-1:0] x);
      int r = 0;
      for (int b = X_W - 1; b >= 0; b--) r = (r * 2 + int'(x[b])) % 503;
      return r;
   endfunction

   function automatic int model_gnt(input logic [NREQ-1:0] vv, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
`ifdef MOD503_SCHED_FIXED_PRIO_EN
         int idx = k;
`else
         int idx = (ptr + k) % NREQ;
`endif
         if (vv[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic logic [X_W-1:0] rand_x();
      logic [X_W-1:0] x = '0;
      for (int w = 0; w < 7; w++) x = {x[X_W-33:0], $urandom()};
      case ($urandom_range(0, 3))
         0: x = X_W'($urandom_range(0, 2000));
         1: x = x | (X_W'(3) << (X_W - 2));
         default: ;
      endcase
      return x;
   endfunction

   function automatic bit queues_empty();
      for (int i = 0; i < NREQ; i++) if (xq[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   // driver: retire accepted operands, load queued ones
   initial begin
      logic [NREQ-1:0] hs;
      for (int i = 0; i < NREQ; i++) xs[i] = '0;
      forever begin
         @(negedge clk);
         hs = rst_n ? (req_valid & req_ready) : '0;
         @(posedge clk);
         #1;
         for (int i = 0; i < NREQ; i++) begin
            if (hs[i]) v[i] = 1'b0;
            if (!v[i] && xq[i].size() != 0) begin
               xs[i] = xq[i].pop_front();
               v[i]  = 1'b1;
            end
         end
      end
   end

   // consumer handshake
   initial forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
         0:       res_ready = 1'b1;
         1:       res_ready = ($urandom_range(0, 3) != 0);
         default: res_ready = 1'b0;
      endcase
   end

   // monitor / scoreboard
   initial forever begin
      int g, was_busy;
      @(negedge clk);
      if (!rst_n) begin
         busy = 0;
         expq.delete();
         rr_m = 0;
      end else begin
         was_busy = busy;
         if (busy != 0) begin
            if (cyc - acc_cyc < LAT)       chk("early_res_valid", res_valid, 0);
            else if (cyc - acc_cyc == LAT) chk("latency", res_valid, 1);
            if (res_valid) begin
               chk("res_id", res_id, expq[0].id);
               chk("res_r", res_r, expq[0].r);
               if (res_ready) begin
                  void'(expq.pop_front());
                  busy = 0;
                  if (tput_on != 0 && last_hs >= 0) chk("period", cyc - last_hs, 25);
                  last_hs = cyc;
               end
            end
         end else begin
            chk("stale_res_valid", res_valid, 0);
         end
         if (was_busy != 0) begin
            chk("ready_while_busy", req_ready, 0);
         end else begin
            g = model_gnt(req_valid, rr_m);
            if (g < 0) begin
               chk("ready_no_valid", req_ready, 0);
            end else begin
               chk("grant", req_ready, longint'(1) << g);
               expq.push_back('{g, mod_ref(xs[g])});
               busy    = 1;
               acc_cyc = cyc;
               rr_m    = (g + 1) % NREQ;
            end
         end
      end
   end

   task automatic drain(input int budget);
      int n = 0;
      while (n < budget && (busy != 0 || expq.size() != 0 || v != '0 || !queues_empty())) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) chk("drain_timeout", n, -1);
      @(negedge clk);
   endtask

   task automatic wait_busy(input int budget);
      int n = 0;
      while (n < budget && busy == 0) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) chk("accept_timeout", n, -1);
   endtask

   initial begin
      logic [X_W-1:0] dx [7];
      logic [X_W-1:0] x1;
      int n;

      // reset state
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_r", res_r, 0);
      chk("rst_res_id", res_id, 0);
      chk("rst_req_ready", req_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_req_ready", req_ready, 0);

      // directed operands on requester 0
      dx[0] = '0;
      dx[1] = X_W'(512);
      dx[2] = X_W'(1) << 18;
      dx[3] = X_W'(1006);
      dx[4] = X_W'(502);
      dx[5] = X_W'(1) << 199;
      dx[6] = {X_W{1'b1}};
      for (int i = 0; i < 7; i++) begin
         xq[0].push_back(dx[i]);
         drain(200);
      end

      // all requesters valid, back-to-back, consumer always ready
      tput_on = 1;
      last_hs = -1;
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < NREQ; i++) xq[i].push_back(rand_x());
      drain(1000);
      tput_on = 0;

      // consumer stall in DONE
      rdy_mode = 2;
      @(negedge clk);
      x1 = rand_x();
      xq[1].push_back(x1);
      wait_busy(50);
      xq[2].push_back(rand_x());
      n = 0;
      while (n < 60 && !res_valid) begin
         @(negedge clk);
         n++;
      end
      if (n >= 60) chk("stall_res_timeout", n, -1);
      for (int k = 0; k < 10; k++) begin
         chk("stall_valid", res_valid, 1);
         chk("stall_r", res_r, mod_ref(x1));
         chk("stall_id", res_id, 1);
         chk("stall_ready", req_ready, 0);
         @(negedge clk);
      end
      rdy_mode = 0;
      drain(300);

      // reset mid-RUN aborts and returns the pointer to 0
      xq[1].push_back(rand_x());
      wait_busy(50);
      repeat (12) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_res_valid", res_valid, 0);
      chk("abort_res_r", res_r, 0);
      chk("abort_res_id", res_id, 0);
      chk("abort_req_ready", req_ready, 0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      xq[1].push_back(rand_x());
      xq[3].push_back(rand_x());
      drain(300);

      // random traffic with a random consumer
      rdy_mode = 1;
      for (int t = 0; t < 40; t++) begin
         xq[$urandom_range(0, NREQ - 1)].push_back(rand_x());
         repeat ($urandom_range(0, 30)) @(negedge clk);
      end
      rdy_mode = 0;
      drain(6000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #600000;
      n_fail++;
      $display("FAIL watchdog: simulation did not complete, at cycle %0d", cyc);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
